// File: rtl/thread_fetch_queue.sv
// Four-thread fetch queue: picks the next thread to fetch, buffers I-cache returns per thread,
// discards wrong-path returns after a flush and issues one instruction per cycle round-robin.
module thread_fetch_queue #(
  parameter int ADDRESS_WIDTH = 22,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset_n,
  input  logic                     i_Stall,
  output logic [1:0]               o_thread_choice,
  output logic                     o_choice_valid,
  input  logic                     i_fetch_valid,
  input  logic [1:0]               i_fetch_thread,
  input  logic [ADDRESS_WIDTH-1:0] i_fetch_pc,
  input  logic [DATA_WIDTH-1:0]    i_fetch_inst,
  input  logic [3:0]               i_flush,
  input  logic                     i_decode_ready,
  output logic                     o_issue_valid,
  output logic [1:0]               o_issue_thread,
  output logic [ADDRESS_WIDTH-1:0] o_issue_pc,
  output logic [DATA_WIDTH-1:0]    o_issue_inst
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDRESS_WIDTH + DATA_WIDTH;
  localparam logic [CW:0] DEPTH_S = (CW+1)'(DEPTH);

  logic [EW-1:0] mem_q [4][DEPTH];

  logic [PW-1:0] rd_q    [4];
  logic [PW-1:0] rd_d    [4];
  logic [PW-1:0] wr_q    [4];
  logic [PW-1:0] wr_d    [4];
  logic [CW-1:0] count_q [4];
  logic [CW-1:0] count_d [4];
  logic [CW-1:0] res_q   [4];
  logic [CW-1:0] res_d   [4];
  logic [CW-1:0] drop_q  [4];
  logic [CW-1:0] drop_d  [4];

  logic [1:0] choice_q, choice_d;
  logic       choice_vld_q, choice_vld_d;
  logic [1:0] fetch_rr_q, fetch_rr_d;
  logic [1:0] issue_rr_q, issue_rr_d;

  logic       launch;
  logic [3:0] launch_t;
  logic [3:0] ret_t;
  logic [3:0] pop_t;
  logic [3:0] push_t;
  logic [3:0] elig;
  logic       issue_vld;
  logic [1:0] issue_thr;

  always_comb begin
    launch = choice_vld_q && !i_Stall;
    for (int t = 0; t < 4; t++) begin
      launch_t[t] = launch && (choice_q == 2'(t));
      ret_t[t]    = i_fetch_valid && (i_fetch_thread == 2'(t));
      // The launch happening on this edge still counts against the slot budget.
      elig[t]     = !i_flush[t] &&
                    (({1'b0, count_q[t]} + {1'b0, res_q[t]} + (CW+1)'(launch_t[t])) < DEPTH_S);
    end
  end

  always_comb begin
    logic [1:0] cand;
    cand         = '0;
    choice_d     = choice_q;
    choice_vld_d = choice_vld_q;
    fetch_rr_d   = fetch_rr_q;
    if (!i_Stall) begin
      choice_vld_d = 1'b0;
      // Scan lowest priority first so the last hit is the first thread after the pointer.
      for (int k = 4; k >= 1; k--) begin
        cand = fetch_rr_q + 2'(k);
        if (elig[cand]) begin
          choice_d     = cand;
          fetch_rr_d   = cand;
          choice_vld_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    logic [1:0] cand;
    cand      = '0;
    issue_vld = 1'b0;
    issue_thr = '0;
    for (int k = 4; k >= 1; k--) begin
      cand = issue_rr_q + 2'(k);
      if ((count_q[cand] != '0) && !i_flush[cand]) begin
        issue_vld = 1'b1;
        issue_thr = cand;
      end
    end
  end

  always_comb begin
    issue_rr_d = issue_rr_q;
    if (issue_vld && i_decode_ready) issue_rr_d = issue_thr;
    for (int t = 0; t < 4; t++) begin
      pop_t[t]   = issue_vld && i_decode_ready && (issue_thr == 2'(t));
      push_t[t]  = 1'b0;
      res_d[t]   = res_q[t] + CW'(launch_t[t]) - CW'(ret_t[t]);
      count_d[t] = count_q[t];
      rd_d[t]    = rd_q[t];
      wr_d[t]    = wr_q[t];
      drop_d[t]  = drop_q[t];
      if (i_flush[t]) begin
        // Every fetch still in flight (including this edge's launch) is wrong-path.
        count_d[t] = '0;
        rd_d[t]    = wr_q[t];
        drop_d[t]  = res_d[t];
      end else begin
        push_t[t] = ret_t[t] && (drop_q[t] == '0);
        if (ret_t[t] && (drop_q[t] != '0)) drop_d[t] = drop_q[t] - CW'(1);
        count_d[t] = count_q[t] + CW'(push_t[t]) - CW'(pop_t[t]);
        wr_d[t]    = wr_q[t] + PW'(push_t[t]);
        rd_d[t]    = rd_q[t] + PW'(pop_t[t]);
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      choice_q     <= '0;
      choice_vld_q <= 1'b0;
      fetch_rr_q   <= 2'd3;
      issue_rr_q   <= 2'd3;
      for (int t = 0; t < 4; t++) begin
        rd_q[t]    <= '0;
        wr_q[t]    <= '0;
        count_q[t] <= '0;
        res_q[t]   <= '0;
        drop_q[t]  <= '0;
      end
    end else begin
      choice_q     <= choice_d;
      choice_vld_q <= choice_vld_d;
      fetch_rr_q   <= fetch_rr_d;
      issue_rr_q   <= issue_rr_d;
      for (int t = 0; t < 4; t++) begin
        rd_q[t]    <= rd_d[t];
        wr_q[t]    <= wr_d[t];
        count_q[t] <= count_d[t];
        res_q[t]   <= res_d[t];
        drop_q[t]  <= drop_d[t];
      end
    end
  end

  // Only one return per cycle, so at most one thread pushes.
  always_ff @(posedge i_Clk) begin
    if (|push_t) mem_q[i_fetch_thread][wr_q[i_fetch_thread]] <= {i_fetch_pc, i_fetch_inst};
  end

  assign o_thread_choice = choice_q;
  assign o_choice_valid  = choice_vld_q;
  assign o_issue_valid   = issue_vld;
  assign o_issue_thread  = issue_thr;
  assign {o_issue_pc, o_issue_inst} = mem_q[issue_thr][rd_q[issue_thr]];

`ifndef SYNTHESIS
  always_ff @(posedge i_Clk) begin
    for (int t = 0; t < 4; t++) begin
      assert (!(i_Reset_n && push_t[t] && (count_q[t] == CW'(DEPTH))))
        else $error("enqueue into full queue on thread %0d", t);
    end
  end
`endif

endmodule

// File: tb/tb_thread_fetch_queue.sv
// Bench for thread_fetch_queue: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-based reference model.
module tb_thread_fetch_queue;

  localparam int AW    = 22;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          stall;
  logic [1:0]    choice;
  logic          cvld;
  logic          fv;
  logic [1:0]    ft;
  logic [AW-1:0] fpc;
  logic [DW-1:0] finst;
  logic [3:0]    flush;
  logic          ready;
  logic          ivld;
  logic [1:0]    ithr;
  logic [AW-1:0] ipc;
  logic [DW-1:0] iinst;

  always #5 clk = ~clk;

  thread_fetch_queue #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_Stall(stall),
    .o_thread_choice(choice), .o_choice_valid(cvld),
    .i_fetch_valid(fv), .i_fetch_thread(ft), .i_fetch_pc(fpc), .i_fetch_inst(finst),
    .i_flush(flush), .i_decode_ready(ready),
    .o_issue_valid(ivld), .o_issue_thread(ithr), .o_issue_pc(ipc), .o_issue_inst(iinst)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: per-thread queues plus in-flight and to-discard counters.
  logic [AW+DW-1:0] mq [4][$];
  int mres [4];
  int mdrop [4];
  int mchoice, mcvld, mfrr, mirr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < 4; t++) begin
      mq[t].delete();
      mres[t]  = 0;
      mdrop[t] = 0;
    end
    mchoice = 0; mcvld = 0; mfrr = 3; mirr = 3;
  endtask

  task automatic model_issue(output int v, output int th);
    v = 0; th = 0;
    for (int k = 1; k <= 4; k++) begin
      int t;
      t = (mirr + k) % 4;
      if (v == 0 && mq[t].size() > 0 && !flush[t]) begin
        v = 1; th = t;
      end
    end
  endtask

  task automatic model_step(input int v, input int th);
    int launch, nxt, ret, lt;
    int sz [4];
    launch = (mcvld != 0 && !stall) ? 1 : 0;
    nxt = -1;
    for (int t = 0; t < 4; t++) sz[t] = mq[t].size();
    if (!stall) begin
      for (int k = 1; k <= 4; k++) begin
        int t;
        t = (mfrr + k) % 4;
        lt = (launch != 0 && mchoice == t) ? 1 : 0;
        if (nxt < 0 && !flush[t] && sz[t] + mres[t] + lt < DEPTH) nxt = t;
      end
    end
    if (v != 0 && ready) begin
      void'(mq[th].pop_front());
      mirr = th;
    end
    for (int t = 0; t < 4; t++) begin
      ret = (fv && ft == 2'(t)) ? 1 : 0;
      lt  = (launch != 0 && mchoice == t) ? 1 : 0;
      mres[t] = mres[t] + lt - ret;
      if (flush[t]) begin
        mq[t].delete();
        mdrop[t] = mres[t];
      end else if (ret != 0) begin
        if (mdrop[t] > 0) mdrop[t]--;
        else mq[t].push_back({fpc, finst});
      end
    end
    if (!stall) begin
      if (nxt >= 0) begin
        mchoice = nxt; mcvld = 1; mfrr = nxt;
      end else begin
        mcvld = 0;
      end
    end
  endtask

  int cur_v, cur_th;

  task automatic settle_check();
    logic [AW+DW-1:0] e;
    #1;
    model_issue(cur_v, cur_th);
    chk("choice", 64'(choice), 64'(mchoice));
    chk("choice_valid", 64'(cvld), 64'(mcvld));
    chk("issue_valid", 64'(ivld), 64'(cur_v));
    if (cur_v != 0) begin
      e = mq[cur_th][0];
      chk("issue_thread", 64'(ithr), 64'(cur_th));
      chk("issue_pc", 64'(ipc), 64'(e[AW+DW-1:DW]));
      chk("issue_inst", 64'(iinst), 64'(e[DW-1:0]));
    end
  endtask

  task automatic advance();
    model_step(cur_v, cur_th);
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    settle_check();
    advance();
  endtask

  task automatic drive(input logic s, input logic v, input logic [1:0] t,
                       input logic [AW-1:0] pc, input logic [3:0] fl, input logic r);
    stall = s; fv = v; ft = t; fpc = pc; finst = $urandom(); flush = fl; ready = r;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 2'd0, '0, 4'b0000, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("reset_choice", 64'(choice), 64'd0);
    chk("reset_choice_valid", 64'(cvld), 64'd0);
    chk("reset_issue_valid", 64'(ivld), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 2'd0, '0, 4'b0000, 1'b0);
    #1;
    do_reset();

    // Free-running choice until every thread has DEPTH fetches outstanding.
    for (int i = 0; i <= 17; i++) begin
      drive(1'b0, 1'b0, 2'd0, '0, 4'b0000, 1'b1);
      settle_check();
      if (i >= 1 && i <= 16) begin
        chk("fill_choice", 64'(choice), 64'((i - 1) % 4));
        chk("fill_valid", 64'(cvld), 64'd1);
      end
      if (i == 17) begin
        chk("full_choice_hold", 64'(choice), 64'd3);
        chk("full_valid", 64'(cvld), 64'd0);
      end
      advance();
    end

    // Thread 0 returns 0x10..0x1C while stalled, then drains in order.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 2'd0, AW'(32'h10 + 4 * i), 4'b0000, 1'b0);
      settle_check();
      if (i == 0) chk("no_bypass", 64'(ivld), 64'd0);
      chk("stall_choice", 64'(choice), 64'd3);
      advance();
    end
    for (int i = 0; i <= 4; i++) begin
      drive(1'b1, 1'b0, 2'd0, '0, 4'b0000, 1'b1);
      settle_check();
      if (i < 4) begin
        chk("t0_order_valid", 64'(ivld), 64'd1);
        chk("t0_order_thread", 64'(ithr), 64'd0);
        chk("t0_order_pc", 64'(ipc), 64'(32'h10 + 4 * i));
      end else begin
        chk("t0_drained", 64'(ivld), 64'd0);
      end
      advance();
    end

    // One entry per thread, returned under a 5-cycle stall, then round-robin issue.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 2'd0, '0, 4'b0000, 1'b0);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, (i < 4), 2'(i), AW'(32'h40 + 4 * i), 4'b0000, 1'b0);
      settle_check();
      chk("stall_frozen_choice", 64'(choice), 64'd0);
      chk("stall_frozen_valid", 64'(cvld), 64'd1);
      advance();
    end
    for (int i = 0; i <= 4; i++) begin
      drive(1'b1, 1'b0, 2'd0, '0, 4'b0000, 1'b1);
      settle_check();
      if (i < 4) begin
        chk("rr_valid", 64'(ivld), 64'd1);
        chk("rr_thread", 64'(ithr), 64'(i));
      end else begin
        chk("rr_empty", 64'(ivld), 64'd0);
      end
      advance();
    end

    // Flush thread 1 with fetches in flight: the stale returns are discarded.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      drive(1'b0, 1'b0, 2'd0, '0, 4'b0000, 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, 2'd1, AW'(32'hA0), 4'b0000, 1'b0); tick();
    drive(1'b1, 1'b1, 2'd1, AW'(32'hA4), 4'b0000, 1'b0); tick();
    drive(1'b1, 1'b0, 2'd0, '0, 4'b0010, 1'b1);
    settle_check();
    chk("flush_no_issue", 64'(ivld), 64'd0);
    advance();
    drive(1'b0, 1'b0, 2'd0, '0, 4'b0000, 1'b1); tick();
    drive(1'b0, 1'b0, 2'd0, '0, 4'b0000, 1'b1);
    settle_check();
    chk("refetch_choice", 64'(choice), 64'd1);
    chk("refetch_valid", 64'(cvld), 64'd1);
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 2'd1, AW'(32'h100 + 4 * i), 4'b0000, 1'b1);
      settle_check();
      chk("discard_empty", 64'(ivld), 64'd0);
      advance();
    end
    drive(1'b1, 1'b0, 2'd0, '0, 4'b0000, 1'b1);
    settle_check();
    chk("post_flush_valid", 64'(ivld), 64'd1);
    chk("post_flush_thread", 64'(ithr), 64'd1);
    chk("post_flush_pc", 64'(ipc), 64'h108);
    advance();

    // Flush thread 2 while it would be the next to issue; thread 0 goes instead.
    drive(1'b1, 1'b1, 2'd2, AW'(32'h200), 4'b0000, 1'b0); tick();
    drive(1'b1, 1'b1, 2'd0, AW'(32'h300), 4'b0000, 1'b0); tick();
    drive(1'b1, 1'b0, 2'd0, '0, 4'b0100, 1'b1);
    settle_check();
    chk("flush_skip_valid", 64'(ivld), 64'd1);
    chk("flush_skip_thread", 64'(ithr), 64'd0);
    chk("flush_skip_pc", 64'(ipc), 64'h300);
    advance();
    drive(1'b1, 1'b0, 2'd0, '0, 4'b0000, 1'b1);
    settle_check();
    chk("t2_flushed_empty", 64'(ivld), 64'd0);
    advance();

    // Random traffic with occasional resets.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(499) == 0) begin
        do_reset();
      end else begin
        logic [1:0] rt;
        logic       rv;
        logic [3:0] rfl;
        rt  = 2'($urandom_range(3));
        rv  = (mres[rt] > 0) && ($urandom_range(1) == 1);
        rfl = ($urandom_range(15) == 0) ? 4'(1 << $urandom_range(3)) : 4'b0000;
        drive(($urandom_range(3) == 0), rv, rt, AW'($urandom()), rfl, ($urandom_range(3) != 0));
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
